// File: rtl/hmem_mem_resp.sv
// hmem_mem_resp: line-burst memory responder with programmable latency behind hmem.
// Define HMEM_MEM_RESP_ADDR_CHECK_EN to flag out-of-range line indices with rsp_err_o instead of wrapping.
module hmem_mem_resp #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 8,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rdata_valid_o,
  input  logic              rdata_ready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_last_o,
  output logic              wr_ack_o,
  output logic              rsp_err_o
);
  localparam int BW  = $clog2(LINE_BEATS);
  localparam int LIW = $clog2(MEM_LINES);
  localparam int OFF = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int LW  = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {IDLE, WDATA, WAIT, ACK, RBURST} state_e;
  state_e            state_q, state_d;
  logic              we_q, we_d, err_q, err_d, oor;
  logic [LIW-1:0]    line_q, line_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [DATA_W-1:0] mem [MEM_LINES*LINE_BEATS];
  logic [DATA_W-1:0] rd_q;
  logic              hs_req, hs_w, hs_r, lat_done, last;
  logic              unused_addr;
  assign unused_addr = ^req_addr_i;
`ifdef HMEM_MEM_RESP_ADDR_CHECK_EN
  assign oor = (req_addr_i >> (OFF + LIW)) != '0;
`else
  assign oor = 1'b0;
`endif
  assign hs_req   = req_valid_i && state_q == IDLE;
  assign hs_w     = wdata_valid_i && state_q == WDATA;
  assign hs_r     = rdata_ready_i && state_q == RBURST;
  assign last     = cnt_q == BW'(LINE_BEATS - 1);
  assign lat_done = state_q == WAIT && lat_q == LW'(LATENCY - 1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      line_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = req_we_i ? WDATA : WAIT;
      WDATA:   if (hs_w && last) state_d = WAIT;
      WAIT:    if (lat_done) state_d = we_q ? ACK : RBURST;
      ACK:     state_d = IDLE;
      RBURST:  if (hs_r && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    we_d   = hs_req ? req_we_i : we_q;
    err_d  = hs_req ? oor : err_q;
    line_d = hs_req ? req_addr_i[OFF +: LIW] : line_q;
    cnt_d  = (hs_w || hs_r) ? cnt_q + 1'b1 : cnt_q;
    lat_d  = (state_q == WAIT && !lat_done) ? lat_q + 1'b1 : '0;
  end
  // Read address follows the next beat count, so rd_q always holds the word for cnt_q.
  always_ff @(posedge clk_i) begin
    if (hs_w && !err_q) mem[{line_q, cnt_q}] <= wdata_i;
    rd_q <= mem[{line_q, cnt_d}];
  end
  always_comb begin
    req_ready_o   = state_q == IDLE;
    wdata_ready_o = state_q == WDATA;
    rdata_valid_o = state_q == RBURST;
    rdata_last_o  = rdata_valid_o && last;
    rdata_o       = (rdata_valid_o && !err_q) ? rd_q : '0;
    wr_ack_o      = state_q == ACK;
    rsp_err_o     = err_q && (rdata_valid_o || wr_ack_o);
  end
endmodule

// File: tb/tb_hmem_mem_resp.sv
// tb_hmem_mem_resp: directed and randomized line bursts against an array-of-lines reference model.
module tb_hmem_mem_resp;
  localparam int LB = 8, ML = 1024, LAT = 4;
  logic        clk = 0, rst_n = 1;
  logic        req_valid = 0, req_we = 0, wdata_valid = 0, rdata_ready = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] wdata = 0;
  logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_ack, rsp_err;
  logic [63:0] rdata;
  int          nvec = 0, nerr = 0;
  logic [63:0] ref_mem [ML][LB];
  logic [63:0] wbuf [LB];
  bit          written [ML];

  hmem_mem_resp dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .wdata_valid_i(wdata_valid),
    .wdata_ready_o(wdata_ready), .wdata_i(wdata), .rdata_valid_o(rdata_valid),
    .rdata_ready_i(rdata_ready), .rdata_o(rdata), .rdata_last_o(rdata_last),
    .wr_ack_o(wr_ack), .rsp_err_o(rsp_err));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
`ifdef HMEM_MEM_RESP_ADDR_CHECK_EN
    return (a >> 6) >= ML;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lidx(input logic [31:0] a);
    return int'((a >> 6) % ML);
  endfunction

  task automatic fill_wbuf_random();
    for (int i = 0; i < LB; i++) wbuf[i] = {$urandom, $urandom};
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", req_ready, 1);
  endtask

  task automatic write_line(input logic [31:0] addr, input bit gaps, input int nb);
    int k;
    bit e = is_err(addr);
    req_valid = 1; req_we = 1; req_addr = addr;
    wait_ready();
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < nb; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        wdata_valid = 0;
        @(negedge clk);
      end
      wdata_valid = 1; wdata = wbuf[i];
      chk("wdata_ready", wdata_ready, 1);
      chk("wr_ack_early", wr_ack, 0);
      @(negedge clk);
    end
    wdata_valid = 0;
    if (!e) for (int i = 0; i < nb; i++) ref_mem[lidx(addr)][i] = wbuf[i];
    if (!e && nb == LB) written[lidx(addr)] = 1;
    if (nb < LB) return;
    // junk beats offered after the burst must be ignored
    k = 1;
    while (!wr_ack && k < 20) begin
      wdata_valid = 1; wdata = {$urandom, $urandom};
      @(negedge clk);
      k++;
    end
    wdata_valid = 0;
    chk("wr_ack_lat", k, LAT + 1);
    chk("wr_err", rsp_err, e);
    @(negedge clk);
    chk("wr_ack_pulse", wr_ack, 0);
    chk("wr_ready_back", req_ready, 1);
  endtask

  task automatic read_line(input logic [31:0] addr, input bit bp, input int stall_beat,
                           input bit hold_next, input logic [31:0] next_addr);
    int k, got, st;
    bit e = is_err(addr);
    int l = lidx(addr);
    logic [63:0] exp;
    req_valid = 1; req_we = 0; req_addr = addr; rdata_ready = 0;
    wait_ready();
    @(negedge clk);
    req_valid = 0;
    k = 1;
    while (!rdata_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_lat", k, LAT + 1);
    if (hold_next) begin
      req_valid = 1; req_we = 0; req_addr = next_addr;
    end
    got = 0; st = 0; k = 0;
    while (got < LB && k < 200) begin
      exp = e ? 64'h0 : ref_mem[l][got];
      chk("rdata", rdata, exp);
      chk("rdata_valid", rdata_valid, 1);
      chk("rdata_last", rdata_last, got == LB - 1);
      chk("rd_err", rsp_err, e);
      if (hold_next) chk("busy_ready", req_ready, 0);
      if (got == stall_beat && st < 3) begin
        rdata_ready = 0;
        st++;
      end else rdata_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rdata_ready) got++;
      @(negedge clk);
      k++;
    end
    rdata_ready = 0;
    chk("rd_beats", got, LB);
    chk("rd_done_valid", rdata_valid, 0);
    chk("rd_ready_back", req_ready, 1);
  endtask

  initial begin
    req_valid = 1; req_addr = 32'h2000;
    #1 rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rdata_valid", rdata_valid, 0);
      chk("rst_wr_ack", wr_ack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", rsp_err, 0);
    end
    rst_n = 1; req_valid = 0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_wready", wdata_ready, 0);

    for (int i = 0; i < LB; i++) wbuf[i] = 64'h1111_0000 + 64'(i);
    write_line(32'h4000, 0, LB);
    read_line(32'h4000, 0, -1, 0, 0);
    read_line(32'h4000, 0, 2, 0, 0);

    fill_wbuf_random();
    write_line(32'h4040, 1, LB);
    read_line(32'h4000, 0, -1, 1, 32'h4040);
    read_line(32'h4040, 1, -1, 0, 0);

    fill_wbuf_random();
    write_line(32'h0, 0, LB);

    fill_wbuf_random();
    write_line(32'h800, 0, LB);
    fill_wbuf_random();
    write_line(32'h800, 0, 4);
    rst_n = 0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_ack", wr_ack, 0);
    end
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("midrst_ack_after", wr_ack, 0);
      chk("midrst_ready", req_ready, 1);
    end
    read_line(32'h800, 0, -1, 0, 0);

    read_line(32'h10000, 0, -1, 0, 0);
    fill_wbuf_random();
    write_line(32'h10000, 1, LB);
    read_line(32'h0, 1, -1, 0, 0);

    for (int it = 0; it < 14; it++) begin
      int l = 32'h300 + $urandom_range(0, 7);
      logic [31:0] a = (32'(l) << 6) | 32'($urandom_range(0, 63));
      if (!written[l] || $urandom_range(0, 1) == 1) begin
        fill_wbuf_random();
        write_line(a, 1, LB);
      end else read_line(a, 1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LB - 1)) : -1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/hmem_mem_resp.md
Name: hmem_mem_resp

Overview:
- Main-memory responder on the far side of the hmem line-transfer interface. hmem is the initiator; this block serves its cache-line fill (read) and writeback (write) bursts.
- Holds a synchronous word array and applies a programmable access latency.
- Used as the memory model behind hmem in simulation and as the on-chip RAM responder in FPGA builds.
- Handles one request at a time; no reordering.

Parameters:
- ADDR_W, 32: byte-address width of req_addr.
- DATA_W, 64: beat width in bits; must be a multiple of 8.
- LINE_BEATS, 8: beats per cache line; power of 2, at least 2.
- MEM_LINES, 1024: number of lines stored; power of 2.
- LATENCY, 4: idle cycles between the end of the request/data phase and the first read beat or write ack; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = line write, 0 = line read.
- req_addr  in  ADDR_W  byte address; offset bits within the line are ignored.
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted.
- wdata  in  DATA_W  write beat data.
- rdata_valid  out  1  read beat valid.
- rdata_ready  in  1  initiator accepts the read beat.
- rdata  out  DATA_W  read beat data.
- rdata_last  out  1  marks the final beat of a line.
- wr_ack  out  1  one-cycle pulse when a line write has completed.
- rsp_err  out  1  error flag; qualified by the rdata_last beat or by wr_ack.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to IDLE; beat counter and latency counter clear.
  - req_ready = 1. wdata_ready, rdata_valid, rdata_last, wr_ack and rsp_err are all 0. rdata = 0.
  - The memory array is not reset.
  - Reset asserted mid-burst abandons the burst. A partially written line keeps the beats already written. No ack is issued.
- Line index = req_addr >> log2(LINE_BEATS*DATA_W/8). Word address = {line index mod MEM_LINES, beat counter}.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch req_we and the line index; req_ready drops the next cycle.
  - Next state is WDATA if req_we = 1, otherwise WAIT.
- WDATA:
  - wdata_ready = 1.
  - Each wdata_valid beat is written to the array at the current beat counter, and the counter increments.
  - After beat LINE_BEATS-1 is accepted, go to WAIT.
  - Gaps in wdata_valid are allowed.
- WAIT:
  - Counts LATENCY cycles.
  - Write: then go to ACK.
  - Read: then go to RBURST with the array read already issued, so rdata_valid rises exactly LATENCY+1 cycles after the request handshake.
- RBURST:
  - rdata_valid = 1 and rdata holds the current beat.
  - On rdata_ready, the counter advances and the next word is presented the next cycle with no bubble. The array is prefetched with a one-word skid register.
  - While rdata_ready = 0, rdata and rdata_last stay stable.
  - rdata_last = 1 on beat LINE_BEATS-1. Its handshake returns the state to IDLE.
- ACK: wr_ack is high for one cycle, then the state returns to IDLE.
- req_valid during a busy state is ignored, because req_ready = 0.
- wdata_valid outside WDATA is ignored.
- The beat counter wraps at LINE_BEATS; bursts always start at beat 0 (critical-word-first is not supported).
- Back-to-back: req_ready returns high the cycle after the last read beat or after wr_ack. A new request may be accepted that cycle.

Optional Feature:
- Macro: HMEM_MEM_RESP_ADDR_CHECK_EN.
- Defined:
  - A request whose line index is >= MEM_LINES does not access the array.
  - Read: returns LINE_BEATS beats of zero, with rsp_err = 1 on every beat.
  - Write: still consumes all LINE_BEATS beats but discards them; wr_ack is issued with rsp_err = 1.
  - Timing is identical to a legal access.
- Undefined: the line index wraps modulo MEM_LINES, and rsp_err is tied to 0.

Test Plan:
- Reset: rst_n low for 3 cycles while req_valid = 1 -> req_ready = 1, rdata_valid = 0, wr_ack = 0 throughout; no request is accepted.
- Write then read: write line 0x100 with beats 0x1111_0000+i (i = 0..7), then read 0x100 (defaults) -> wr_ack 5 cycles after the last write beat; rdata_valid first high 5 cycles after the read handshake; beats return in order, rdata_last on the 8th.
- Read backpressure: drop rdata_ready for 3 cycles at beat 2 -> rdata stays at beat 2 while stalled; no beats duplicated or lost; total of 8 handshakes.
- Busy lockout: assert a second req_valid during a read burst -> req_ready = 0 until the cycle after the rdata_last handshake, then the second request is accepted.
- Reset mid-burst: assert rst_n low after write beat 3 -> no wr_ack; a subsequent read shows beats 0..3 new and beats 4..7 old.
- With HMEM_MEM_RESP_ADDR_CHECK_EN: read at line index MEM_LINES -> 8 zero beats with rsp_err = 1. Without the macro, the same read returns the contents of line 0.
